// File: rtl/weight_packer_pkg.sv
// Shared definitions for the weight packer slice.
//   SYM_W_DEF / LANES_DEF : default symbol width and lanes per L0 row
//   ROW_W_DEF             : default packed row width (LANES_DEF*SYM_W_DEF)
//   state_t               : packer FSM states
//   row_width()           : packed row width for a given lanes/symbol width
package weight_packer_pkg;

  localparam int unsigned SYM_W_DEF = 4;
  localparam int unsigned LANES_DEF = 8;
  localparam int unsigned ROW_W_DEF = LANES_DEF * SYM_W_DEF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_OVF   = 2'd2
  } state_t;

  function automatic int unsigned row_width(input int unsigned lanes,
                                            input int unsigned sym_w);
    return lanes * sym_w;
  endfunction

endpackage

// File: rtl/weight_packer_row_fifo.sv
// row_fifo: synchronous first-word-fall-through FIFO for completed rows.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   push        : write push_data (taken when not full, or when full with a pop)
//   push_data   : row to store
//   pop         : discard the head entry (ignored when empty)
//   head        : current head entry, forced to 0 while empty
//   full, empty : occupancy flags
//   count       : current occupancy
module row_fifo
  import weight_packer_pkg::*;
#(
  parameter int unsigned WIDTH = ROW_W_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push while full is still taken.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/weight_packer.sv
// weight_packer: packs decoded 4-bit weight symbols into full L0 rows.
// Symbols fill lanes from lane 0 upward; each completed row is pushed into a
// small FWFT FIFO that feeds the L0 write port.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   symbol_in    : decoded symbol; symbol_valid marks a one-cycle pulse
//   flush        : pad and emit the partial row (only with WEIGHT_PACKER_FLUSH_EN)
//   out_row      : FIFO head row; out_valid flags it; out_ready pops it
//   afull        : registered, occupancy >= FIFO_DEPTH-1
//   overflow     : sticky, a completed row was dropped (FSM parks in ST_OVF)
//   tile_done    : one-cycle pulse after the last row of a tile is popped
// Build option: define WEIGHT_PACKER_FLUSH_EN to add the flush port and ST_FLUSH.
module weight_packer
  import weight_packer_pkg::*;
#(
  parameter int unsigned LANES         = LANES_DEF,
  parameter int unsigned SYM_W         = SYM_W_DEF,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned ROWS_PER_TILE = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SYM_W-1:0]       symbol_in,
  input  logic                   symbol_valid,
`ifdef WEIGHT_PACKER_FLUSH_EN
  input  logic                   flush,
`endif
  output logic [LANES*SYM_W-1:0] out_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   afull,
  output logic                   overflow,
  output logic                   tile_done
);

  localparam int unsigned ROW_W  = row_width(LANES, SYM_W);
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned TILE_W = $clog2(ROWS_PER_TILE);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [LANE_W-1:0] LAST_LANE     = LANE_W'(LANES - 1);
  localparam logic [TILE_W-1:0] LAST_TILE_ROW = TILE_W'(ROWS_PER_TILE - 1);
  localparam logic [CNT_W-1:0]  AFULL_LVL     = CNT_W'(FIFO_DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic [ROW_W-1:0]  acc;
  logic [ROW_W-1:0]  acc_next;
  logic [ROW_W-1:0]  base_acc;
  logic [ROW_W-1:0]  row_next;
  logic [ROW_W-1:0]  push_row;
  logic [LANE_W-1:0] lane_cnt;
  logic [LANE_W-1:0] lane_next;
  logic [LANE_W-1:0] base_lane;
  logic [TILE_W-1:0] tile_cnt;
  logic              accept;
  logic              complete;
  logic              push_req;
  logic              drop;
  logic              fifo_push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_next;

  assign out_valid = !fifo_empty;
  assign pop       = !fifo_empty && out_ready;

  always_comb begin
    state_next = state;
    accept     = symbol_valid && (state != ST_OVF);
    base_acc   = acc;
    base_lane  = lane_cnt;
`ifdef WEIGHT_PACKER_FLUSH_EN
    // ST_FLUSH pushes the held partial row, so a symbol arriving now starts
    // a fresh row at lane 0 rather than extending the one being emitted.
    if (state == ST_FLUSH) begin
      base_acc  = '0;
      base_lane = '0;
    end
`endif

    row_next = base_acc;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (accept && (base_lane == LANE_W'(k))) begin
        row_next[k*SYM_W +: SYM_W] = symbol_in;
      end
    end

    complete  = accept && (base_lane == LAST_LANE);
    acc_next  = complete ? '0 : row_next;
    lane_next = complete ? '0 : (accept ? base_lane + LANE_W'(1) : base_lane);
    push_req  = complete;
    push_row  = row_next;

`ifdef WEIGHT_PACKER_FLUSH_EN
    if (state == ST_FLUSH) begin
      push_req   = 1'b1;
      push_row   = acc;
      state_next = ST_RUN;
    end else if ((state == ST_RUN) && flush && !complete &&
                 ((lane_cnt != '0) || accept)) begin
      state_next = ST_FLUSH;
    end
`endif

    drop      = push_req && fifo_full && !pop;
    fifo_push = push_req && !drop;
    if (drop) begin
      state_next = ST_OVF;
    end

    count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      lane_cnt  <= '0;
      tile_cnt  <= '0;
      afull     <= 1'b0;
      overflow  <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      acc       <= acc_next;
      lane_cnt  <= lane_next;
      afull     <= (count_next >= AFULL_LVL);
      overflow  <= overflow | drop;
      tile_done <= 1'b0;
      if (pop) begin
        if (tile_cnt == LAST_TILE_ROW) begin
          tile_cnt  <= '0;
          tile_done <= 1'b1;
        end else begin
          tile_cnt <= tile_cnt + TILE_W'(1);
        end
      end
    end
  end

  row_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_row),
    .pop       (pop),
    .head      (out_row),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_weight_packer.sv
// Self-checking bench for weight_packer (default parameters: 8 lanes x 4 bits,
// FIFO depth 4, 8 rows per tile). Flush tests are built only when
// WEIGHT_PACKER_FLUSH_EN is defined.
module tb_weight_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  symbol_in = '0;
  logic        symbol_valid = 1'b0;
`ifdef WEIGHT_PACKER_FLUSH_EN
  logic        flush = 1'b0;
`endif
  logic [31:0] out_row;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        afull;
  logic        overflow;
  logic        tile_done;

  weight_packer #(
    .LANES         (8),
    .SYM_W         (4),
    .FIFO_DEPTH    (4),
    .ROWS_PER_TILE (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .symbol_in    (symbol_in),
    .symbol_valid (symbol_valid),
`ifdef WEIGHT_PACKER_FLUSH_EN
    .flush        (flush),
`endif
    .out_row      (out_row),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .afull        (afull),
    .overflow     (overflow),
    .tile_done    (tile_done)
  );

  always #5 clk = ~clk;

  // seq lists symbols in send order, first symbol in the top nibble.
  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] sb [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          pops_seen = 0;
  int          tile_pulses = 0;
  int          tile_at = -1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  function automatic logic [3:0] nib(input logic [31:0] s, input int i);
    return s[31-4*i -: 4];
  endfunction

  // Scoreboard: each popped row is compared against the oldest expected row.
  always @(negedge clk) begin
    if (!reset) begin
      if (tile_done) begin
        tile_pulses++;
        tile_at = pops_seen;
      end
      if (out_valid && out_ready) begin
        pops_seen++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_row: got %h, required no row", out_row);
        end else begin
          check("row", out_row, sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] s, input bit fl);
    symbol_in    = s;
    symbol_valid = 1'b1;
`ifdef WEIGHT_PACKER_FLUSH_EN
    flush        = fl;
`endif
    tick();
    symbol_valid = 1'b0;
`ifdef WEIGHT_PACKER_FLUSH_EN
    flush        = 1'b0;
`endif
  endtask

  task automatic send_row(input vec_t v, input bit expect_push);
    for (int i = 0; i < 8; i++) send(nib(v.seq, i), 1'b0);
    if (expect_push) sb.push_back(v.exp);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    symbol_valid = 1'b0;
    out_ready    = 1'b0;
    tick();
    tick();
    reset       = 1'b0;
    sb.delete();
    pops_seen   = 0;
    tile_pulses = 0;
    tile_at     = -1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    check(name, sb.size(), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    vecs[0] = '{seq: 32'h12345678, exp: 32'h87654321};
    vecs[1] = '{seq: 32'hFEDCBA98, exp: 32'h89ABCDEF};
    vecs[2] = '{seq: 32'h00000000, exp: 32'h00000000};
    vecs[3] = '{seq: 32'hF0000000, exp: 32'h0000000F};
    vecs[4] = '{seq: 32'h0000000F, exp: 32'hF0000000};
    vecs[5] = '{seq: 32'hA5A5A5A5, exp: 32'h5A5A5A5A};
    vecs[6] = '{seq: 32'h13579BDF, exp: 32'hFDB97531};
    vecs[7] = '{seq: 32'h2468ACE0, exp: 32'h0ECA8642};

    // Reset values
    do_reset();
    check("rst_out_row", out_row, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_afull", afull, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tile_done", tile_done, 0);

    // Latency: row visible the cycle after the 8th symbol, for one cycle
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(nib(vecs[0].seq, i), 1'b0);
    check("lat_before", out_valid, 0);
    sb.push_back(vecs[0].exp);
    send(nib(vecs[0].seq, 7), 1'b0);
    check("lat_valid", out_valid, 1);
    check("lat_row", out_row, 32'h87654321);
    tick();
    check("lat_one_cycle", out_valid, 0);

    // Table: 64 back-to-back symbols -> 8 rows, one tile_done on the 8th pop
    do_reset();
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) send_row(vecs[v], 1'b1);
    wait_drain("tile_drain");
    idle(2);
    check("tile_pops", pops_seen, 8);
    check("tile_pulses", tile_pulses, 1);
    check("tile_at_pop", tile_at, 8);

    // Overflow: afull after 3 rows, 5th row dropped, exactly 4 rows drain
    do_reset();
    send_row(vecs[1], 1'b1);
    send_row(vecs[2], 1'b1);
    check("afull_2rows", afull, 0);
    send_row(vecs[3], 1'b1);
    check("afull_3rows", afull, 1);
    send_row(vecs[4], 1'b1);
    check("ovf_4rows", overflow, 0);
    send_row(vecs[5], 1'b0);
    check("ovf_set", overflow, 1);
    out_ready = 1'b1;
    wait_drain("ovf_drain");
    send_row(vecs[6], 1'b0);
    idle(10);
    check("ovf_pops", pops_seen, 4);
    check("ovf_ignored", out_valid, 0);
    check("ovf_sticky", overflow, 1);
    check("ovf_afull_low", afull, 0);

    // Full FIFO, row completes in the same cycle as a pop
    do_reset();
    for (int v = 0; v < 4; v++) send_row(vecs[v], 1'b1);
    for (int i = 0; i < 7; i++) send(nib(vecs[5].seq, i), 1'b0);
    out_ready = 1'b1;
    send(nib(vecs[5].seq, 7), 1'b0);
    out_ready = 1'b0;
    sb.push_back(vecs[5].exp);
    check("simul_no_ovf", overflow, 0);
    check("simul_afull", afull, 1);
    send_row(vecs[6], 1'b0);
    check("simul_still_full", overflow, 1);
    out_ready = 1'b1;
    wait_drain("simul_drain");
    check("simul_pops", pops_seen, 5);

    // Reset mid-operation with rows queued and a partial row
    do_reset();
    send_row(vecs[1], 1'b1);
    send_row(vecs[2], 1'b1);
    send_row(vecs[3], 1'b1);
    for (int i = 0; i < 5; i++) send(nib(vecs[7].seq, i), 1'b0);
    check("mid_afull_pre", afull, 1);
    do_reset();
    check("mid_out_row", out_row, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_afull", afull, 0);
    check("mid_overflow", overflow, 0);
    check("mid_tile_done", tile_done, 0);
    out_ready = 1'b1;
    send_row(vecs[6], 1'b1);
    wait_drain("mid_drain");
    check("mid_pops", pops_seen, 1);

`ifdef WEIGHT_PACKER_FLUSH_EN
    // Flush a partial row A,B,C
    do_reset();
    out_ready = 1'b1;
    send(4'hA, 1'b0);
    send(4'hB, 1'b0);
    send(4'hC, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.push_back(32'h00000CBA);
    wait_drain("flush_drain");
    check("flush_pops", pops_seen, 1);
    // Flush with an empty row is a no-op
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle(4);
    check("flush_empty_pops", pops_seen, 1);
    check("flush_empty_valid", out_valid, 0);
    // Symbol with flush, then a symbol during ST_FLUSH starts the fresh row
    send(4'hD, 1'b1);
    sb.push_back(32'h0000000D);
    send(4'hE, 1'b0);
    for (int i = 1; i < 8; i++) send(4'(i), 1'b0);
    sb.push_back(32'h7654321E);
    wait_drain("flush_sym_drain");
    check("flush_sym_pops", pops_seen, 3);
    // Flush with a row-completing symbol emits only that row
    for (int i = 0; i < 7; i++) send(nib(vecs[6].seq, i), 1'b0);
    send(nib(vecs[6].seq, 7), 1'b1);
    sb.push_back(vecs[6].exp);
    wait_drain("flush_full_drain");
    idle(4);
    check("flush_full_pops", pops_seen, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
